// File: rtl/cga_trap_pkg.sv
// Shared definitions for the CGA trap/break sequencer: cause indices, FSM encoding, vector defaults.
// CGA_TRAP_DBLFAULT_EN adds the HALT state used after a double fault.
package cga_trap_pkg;

  localparam int NCAUSE_DEF = 8;
  localparam int CAUSE_W    = 3;

  localparam int CAUSE_PGF   = 0;
  localparam int CAUSE_IPV   = 1;
  localparam int CAUSE_WIP   = 2;
  localparam int CAUSE_RD    = 3;
  localparam int CAUSE_RV    = 4;
  localparam int CAUSE_VTRAP = 5;
  localparam int CAUSE_FTRAP = 6;
  localparam int CAUSE_INTR  = 7;

  localparam logic [11:0] VEC_BASE_DEF   = 12'h080;
  localparam int          VEC_STRIDE_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
`ifdef CGA_TRAP_DBLFAULT_EN
    ST_SERVICE,
    ST_HALT
`else
    ST_SERVICE
`endif
  } state_t;

  // Handler entry address; arithmetic deliberately wraps modulo 4096.
  function automatic logic [11:0] vec_addr(input logic [11:0] base, input int stride,
                                           input logic [CAUSE_W-1:0] idx);
    return base + 12'(int'(idx) * stride);
  endfunction

endpackage

// File: rtl/cga_trap_prienc.sv
// Combinational priority encoder: lowest set request bit wins; any flags a non-empty request.
module cga_trap_prienc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/cga_trap_seq.sv
// CGA trap/break consumer: captures causes, presents handler vectors via TREQ/TACK, tracks occupancy.
// Optional CGA_TRAP_DBLFAULT_EN adds double-fault detection and the sticky HALTN output.
//
// state   | meaning
// IDLE    | nothing pending, waiting for a qualified cause
// SELECT  | priority-encode PENDING, register TCAUSE/TVEC
// REQ     | vector presented, waiting for TACK
// SERVICE | handler running, waiting for THDONE
// HALT    | double fault, presenting the halt vector until reset (macro builds only)
module cga_trap_seq
  import cga_trap_pkg::*;
#(
  parameter int          NCAUSE     = NCAUSE_DEF,
  parameter logic [11:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int          VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic               sysclk,
  input  logic               sys_rst_n,
  input  logic               BRKN,
  input  logic               TRAPN,
  input  logic [NCAUSE-1:0]  CAUSEN,
  input  logic               TACK,
  input  logic               THDONE,
  output logic               TREQ,
  output logic [11:0]        TVEC,
  output logic [CAUSE_W-1:0] TCAUSE,
  output logic               INHAND,
  output logic               ABORTN,
`ifdef CGA_TRAP_DBLFAULT_EN
  output logic [NCAUSE-1:0]  PENDING,
  output logic               HALTN
`else
  output logic [NCAUSE-1:0]  PENDING
`endif
);

  state_t              state_q, state_d;
  logic [NCAUSE-1:0]   set_v, clr_v, pend_next, pend_d;
  logic [CAUSE_W-1:0]  enc_idx;
  logic                enc_any;
  logic                ack, done, treq_d;
`ifdef CGA_TRAP_DBLFAULT_EN
  logic                dbl;
`endif

  cga_trap_prienc #(.N(NCAUSE), .W(CAUSE_W)) u_prienc (
    .req (PENDING),
    .idx (enc_idx),
    .any (enc_any)
  );

  assign ack  = TREQ & TACK & (state_q == ST_REQ);
  assign done = THDONE & (state_q == ST_SERVICE);

  always_comb begin
    set_v = (!TRAPN || !BRKN) ? ~CAUSEN : '0;
    clr_v = '0;
    if (ack) clr_v[TCAUSE] = 1'b1;
    pend_next = (PENDING & ~clr_v) | set_v;
  end

`ifdef CGA_TRAP_DBLFAULT_EN
  // The ack cycle already belongs to the handler, so a repeat of the acked cause counts.
  always_comb begin
    dbl = (state_q != ST_HALT) && (INHAND || ack) && set_v[TCAUSE] &&
          (TCAUSE != CAUSE_W'(CAUSE_INTR));
    pend_d = (dbl || state_q == ST_HALT) ? PENDING : pend_next;
  end
`else
  assign pend_d = pend_next;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (|pend_d) state_d = ST_SELECT;
      ST_SELECT:  state_d = enc_any ? ST_REQ : ST_IDLE;
      ST_REQ:     if (ack) state_d = ST_SERVICE;
      ST_SERVICE: if (THDONE) state_d = (|pend_d) ? ST_SELECT : ST_IDLE;
`ifdef CGA_TRAP_DBLFAULT_EN
      ST_HALT:    state_d = ST_HALT;
`endif
      default:    state_d = ST_IDLE;
    endcase
`ifdef CGA_TRAP_DBLFAULT_EN
    if (dbl) state_d = ST_HALT;
`endif
    // TREQ rises one cycle after entering REQ and drops right after the accepting edge.
    treq_d = (state_q == ST_REQ) && !ack;
`ifdef CGA_TRAP_DBLFAULT_EN
    if (state_d == ST_HALT) treq_d = 1'b1;
`endif
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      PENDING <= '0;
      TREQ    <= 1'b0;
      TVEC    <= '0;
      TCAUSE  <= '0;
      INHAND  <= 1'b0;
      ABORTN  <= 1'b1;
    end else begin
      state_q <= state_d;
      PENDING <= pend_d;
      TREQ    <= treq_d;
      if (state_q == ST_SELECT) begin
        TCAUSE <= enc_idx;
        TVEC   <= vec_addr(VEC_BASE, VEC_STRIDE, enc_idx);
      end
      if (ack)       INHAND <= 1'b1;
      else if (done) INHAND <= 1'b0;
      if (!BRKN)     ABORTN <= 1'b0;
      else if (ack)  ABORTN <= 1'b1;
`ifdef CGA_TRAP_DBLFAULT_EN
      if (dbl) begin
        TVEC   <= VEC_BASE - 12'(VEC_STRIDE);
        INHAND <= 1'b0;
      end
`endif
    end
  end

`ifdef CGA_TRAP_DBLFAULT_EN
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n)  HALTN <= 1'b1;
    else if (dbl)    HALTN <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_cga_trap_seq.sv
// Self-checking bench for cga_trap_seq: scoreboard of expected vectors, one task per scenario.
module tb_cga_trap_seq;
  import cga_trap_pkg::*;

  logic        sysclk = 1'b0;
  logic        sys_rst_n;
  logic        BRKN, TRAPN, TACK, THDONE;
  logic [7:0]  CAUSEN;
  logic        TREQ, INHAND, ABORTN;
  logic [11:0] TVEC;
  logic [2:0]  TCAUSE;
  logic [7:0]  PENDING;
`ifdef CGA_TRAP_DBLFAULT_EN
  logic        HALTN;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [14:0] exp_q[$];

  always #5 sysclk = ~sysclk;

  cga_trap_seq dut (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .BRKN      (BRKN),
    .TRAPN     (TRAPN),
    .CAUSEN    (CAUSEN),
    .TACK      (TACK),
    .THDONE    (THDONE),
    .TREQ      (TREQ),
    .TVEC      (TVEC),
    .TCAUSE    (TCAUSE),
    .INHAND    (INHAND),
    .ABORTN    (ABORTN),
`ifdef CGA_TRAP_DBLFAULT_EN
    .PENDING   (PENDING),
    .HALTN     (HALTN)
`else
    .PENDING   (PENDING)
`endif
  );

  function automatic logic [14:0] exp_entry(input int i);
    logic [11:0] v;
    v = 12'h080 + 12'(i * 4);
    return {3'(i), v};
  endfunction

  task automatic push_mask(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) exp_q.push_back(exp_entry(i));
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic idle_inputs;
    BRKN = 1'b1; TRAPN = 1'b1; CAUSEN = 8'hFF; TACK = 1'b0; THDONE = 1'b0;
  endtask

  task automatic wait_treq(input string tag);
    int k;
    k = 0;
    while (TREQ !== 1'b1 && k < 20) begin cyc(); k++; end
    n_checks++;
    if (TREQ !== 1'b1) begin
      n_fail++;
      $display("FAIL %s treq_timeout: TREQ=%b after %0d cycles, required 1", tag, TREQ, k);
    end
  endtask

  task automatic pop_compare(input string tag);
    logic [14:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard_empty: DUT presented TVEC=%h with no expectation", tag, TVEC);
    end else begin
      e = exp_q.pop_front();
      if (TVEC !== e[11:0] || TCAUSE !== e[14:12]) begin
        n_fail++;
        $display("FAIL %s vector: TVEC=%h TCAUSE=%0d, required TVEC=%h TCAUSE=%0d",
                 tag, TVEC, TCAUSE, e[11:0], e[14:12]);
      end
    end
  endtask

  task automatic serve_next(input string tag);
    wait_treq(tag);
    pop_compare(tag);
    TACK = 1'b1; cyc(); TACK = 1'b0;
    n_checks++;
    if (TREQ !== 1'b0 || INHAND !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ack: TREQ=%b INHAND=%b, required 0 1", tag, TREQ, INHAND);
    end
    cyc(2);
    n_checks++;
    if (INHAND !== 1'b1 || TREQ !== 1'b0) begin
      n_fail++;
      $display("FAIL %s service_hold: INHAND=%b TREQ=%b, required 1 0", tag, INHAND, TREQ);
    end
    THDONE = 1'b1; cyc(); THDONE = 1'b0;
    n_checks++;
    if (INHAND !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done: INHAND=%b, required 0", tag, INHAND);
    end
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      BRKN = 1'($urandom_range(0, 1)); TRAPN = 1'($urandom_range(0, 1));
      CAUSEN = 8'($urandom); TACK = 1'($urandom_range(0, 1)); THDONE = 1'($urandom_range(0, 1));
      cyc();
      n_checks++;
      if (TREQ !== 1'b0 || ABORTN !== 1'b1 || PENDING !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_hold: TREQ=%b ABORTN=%b PENDING=%h, required 0 1 00", TREQ, ABORTN, PENDING);
      end
    end
    idle_inputs;
    sys_rst_n = 1'b1;
    cyc(4);
    n_checks++;
    if (TREQ !== 1'b0 || TVEC !== 12'h000 || TCAUSE !== 3'd0 || INHAND !== 1'b0 ||
        ABORTN !== 1'b1 || PENDING !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release: TREQ=%b TVEC=%h TCAUSE=%0d INHAND=%b ABORTN=%b PENDING=%h, required 0 000 0 0 1 00",
               TREQ, TVEC, TCAUSE, INHAND, ABORTN, PENDING);
    end
  endtask

  task automatic test_single;
    TRAPN = 1'b0; CAUSEN = 8'hFE; push_mask(8'h01);
    cyc(); idle_inputs;
    n_checks++;
    if (PENDING !== 8'h01 || TREQ !== 1'b0) begin
      n_fail++;
      $display("FAIL single_capture: PENDING=%h TREQ=%b, required 01 0", PENDING, TREQ);
    end
    cyc();
    n_checks++;
    if (TREQ !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency_early: TREQ=%b one edge after capture, required 0", TREQ);
    end
    cyc();
    n_checks++;
    if (TREQ !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: TREQ=%b two edges after capture, required 1", TREQ);
    end
    serve_next("single");
    cyc(3);
    n_checks++;
    if (PENDING !== 8'h00 || TREQ !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: PENDING=%h TREQ=%b, required 00 0", PENDING, TREQ);
    end
  endtask

  task automatic test_priority;
    TRAPN = 1'b0; CAUSEN = 8'h5F; push_mask(~8'h5F);
    cyc(); idle_inputs;
    serve_next("priority_first");
    n_checks++;
    if (PENDING !== 8'h80) begin
      n_fail++;
      $display("FAIL priority_queued: PENDING=%h, required 80", PENDING);
    end
    serve_next("priority_second");
    cyc();
    n_checks++;
    if (PENDING !== 8'h00) begin
      n_fail++;
      $display("FAIL priority_drained: PENDING=%h, required 00", PENDING);
    end
  endtask

  task automatic test_gating;
    for (int i = 0; i < 5; i++) begin
      TRAPN = 1'b1; BRKN = 1'b1; CAUSEN = 8'h00;
      TACK = 1'(i & 1); THDONE = 1'((i >> 1) & 1);
      cyc();
      n_checks++;
      if (PENDING !== 8'h00 || TREQ !== 1'b0 || INHAND !== 1'b0 || ABORTN !== 1'b1) begin
        n_fail++;
        $display("FAIL gating: PENDING=%h TREQ=%b INHAND=%b ABORTN=%b, required 00 0 0 1",
                 PENDING, TREQ, INHAND, ABORTN);
      end
    end
    idle_inputs; cyc(2);
  endtask

  task automatic test_break;
    BRKN = 1'b0; CAUSEN = 8'hBF; push_mask(8'h40);
    cyc(); idle_inputs;
    n_checks++;
    if (ABORTN !== 1'b0 || PENDING !== 8'h40) begin
      n_fail++;
      $display("FAIL break_abort: ABORTN=%b PENDING=%h, required 0 40", ABORTN, PENDING);
    end
    wait_treq("break");
    pop_compare("break");
    n_checks++;
    if (ABORTN !== 1'b0) begin
      n_fail++;
      $display("FAIL break_abort_hold: ABORTN=%b before ack, required 0", ABORTN);
    end
    TACK = 1'b1; cyc(); TACK = 1'b0;
    n_checks++;
    if (ABORTN !== 1'b1 || INHAND !== 1'b1) begin
      n_fail++;
      $display("FAIL break_abort_release: ABORTN=%b INHAND=%b, required 1 1", ABORTN, INHAND);
    end
    THDONE = 1'b1; cyc(); THDONE = 1'b0; cyc(2);
  endtask

  task automatic test_back_to_back;
    TRAPN = 1'b0; CAUSEN = 8'h00; push_mask(8'hFF);
    cyc(); idle_inputs;
    for (int i = 0; i < 8; i++) serve_next("back_to_back");
    cyc();
    n_checks++;
    if (PENDING !== 8'h00 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL back_to_back_drained: PENDING=%h left=%0d, required 00 0", PENDING, exp_q.size());
    end
  endtask

  task automatic test_collision;
    TRAPN = 1'b0; CAUSEN = 8'hFB; push_mask(8'h04);
    cyc(); idle_inputs;
    wait_treq("collision");
    pop_compare("collision");
    TACK = 1'b1; TRAPN = 1'b0; CAUSEN = 8'hFB;
    cyc(); idle_inputs;
`ifdef CGA_TRAP_DBLFAULT_EN
    n_checks++;
    if (HALTN !== 1'b0 || TREQ !== 1'b1 || TVEC !== 12'h07C) begin
      n_fail++;
      $display("FAIL collision_dblfault: HALTN=%b TREQ=%b TVEC=%h, required 0 1 07C", HALTN, TREQ, TVEC);
    end
    sys_rst_n = 1'b0; cyc(); sys_rst_n = 1'b1; cyc();
`else
    n_checks++;
    if (PENDING[2] !== 1'b1 || INHAND !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_set_wins: PENDING=%h INHAND=%b, required bit2=1 1", PENDING, INHAND);
    end
    push_mask(8'h04);
    cyc(2);
    THDONE = 1'b1; cyc(); THDONE = 1'b0;
    serve_next("collision_reserve");
    cyc();
    n_checks++;
    if (PENDING !== 8'h00) begin
      n_fail++;
      $display("FAIL collision_drained: PENDING=%h, required 00", PENDING);
    end
`endif
  endtask

  task automatic test_reset_inflight;
    TRAPN = 1'b0; CAUSEN = 8'hF7; push_mask(8'h08);
    cyc(); idle_inputs; BRKN = 1'b0;
    cyc(); BRKN = 1'b1;
    wait_treq("reset_inflight");
    pop_compare("reset_inflight");
    #1 sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (TREQ !== 1'b0 || PENDING !== 8'h00 || ABORTN !== 1'b1 || TVEC !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_inflight: TREQ=%b PENDING=%h ABORTN=%b TVEC=%h, required 0 00 1 000",
               TREQ, PENDING, ABORTN, TVEC);
    end
    cyc(); sys_rst_n = 1'b1; cyc(4);
    n_checks++;
    if (TREQ !== 1'b0 || INHAND !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_inflight_quiet: TREQ=%b INHAND=%b, required 0 0", TREQ, INHAND);
    end
  endtask

  initial begin
    idle_inputs;
    test_reset;
    test_single;
    test_priority;
    test_gating;
    test_break;
    test_back_to_back;
    test_collision;
    test_reset_inflight;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
